obstacle_sequencer: RTL and testbench
=====================================

Name: obstacle_sequencer

Overview:
Schedules which obstacle pattern the playfield receives on each scroll tick. Drives the 5-bit index of the existing obstacle ROM (indices 0–15 are patterns, 16 is the bonus row, all others blank) and samples its 7-bit pattern. Inserts blank gap rows between obstacles and a bonus row at a fixed cadence. Publishes a difficulty level that the tick divider uses to speed up scrolling. Sits between the game-control FSM and the playfield shift register.

Parameters:
GAP_ROWS, 2, blank rows emitted after every obstacle or bonus row (0 = back-to-back, range 0–7)
BONUS_EVERY, 8, obstacle rows between bonus rows (range 1–15)
ROWS_PER_LEVEL, 16, obstacle rows per level increment (range 1–255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse that starts or restarts a run
pause  in  1  level; while high, ticks are ignored and all state is held
game_over  in  1  one-cycle pulse that ends the run
tick  in  1  one-cycle scroll strobe from the tick divider
tipo_obs  out  5  registered ROM index
obstaculo  in  7  ROM pattern for tipo_obs (combinational)
row_out  out  7  row delivered to the playfield (bit=1 means obstacle lane)
row_valid  out  1  one-cycle strobe; row_out is valid
row_is_bonus  out  1  high with row_valid when row_out is the bonus row
level  out  3  difficulty level, saturates at 7
busy  out  1  high in OBST or GAP

Behaviour:
- Reset: state=IDLE, tipo_obs=0, row_out=0, row_valid=0, row_is_bonus=0, level=0, busy=0; all internal counters=0.
- States and transitions:
  - IDLE: start → OBST, with seq_idx=0, tipo_obs=0, counters cleared.
  - OBST: on an accepted tick, emit a row. Go to GAP if GAP_ROWS>0, otherwise stay in OBST.
  - GAP: on an accepted tick, emit row_out=0 and increment gap_cnt. When gap_cnt reaches GAP_ROWS, clear it and go to OBST.
  - OVER: row_valid=0 and row_out=0; holds until start, which behaves exactly as start from IDLE.
- Accepted tick = tick & ~pause in OBST or GAP. Ticks in IDLE or OVER are ignored.
- Latency: row_valid rises the cycle after an accepted tick. row_out and row_is_bonus are registered with it. row_valid is high for exactly one cycle.
- Pattern emission in OBST:
  - row_out <= obstaculo for the tipo_obs value held at the tick.
  - If tipo_obs==16: row_is_bonus=1, bonus_cnt cleared, seq_idx unchanged.
  - Otherwise: seq_idx <= (seq_idx+1) mod 16, bonus_cnt++, obs_cnt++.
- Index preload: tipo_obs is updated in the same cycle as the emission for the next OBST slot. It becomes 16 if bonus_cnt (post-update) == BONUS_EVERY, otherwise the new seq_idx. tipo_obs never leaves the range 0–16.
- Level:
  - When obs_cnt (post-update) == ROWS_PER_LEVEL: obs_cnt=0 and level++.
  - Level saturates at 7; obs_cnt keeps cycling after saturation.
  - Bonus rows do not count toward obs_cnt.
- Wrap-around: seq_idx wraps 15→0. The bonus slot is inserted without consuming a sequence index.
- Priority (highest first): rst > game_over > start > tick.
  - game_over in any state → OVER on the next edge; a tick in the same cycle is dropped.
  - start while in OBST or GAP is ignored.
  - start and game_over in the same cycle: game_over wins.
- Pause: all registers, including gap_cnt and level, are frozen. row_valid stays 0.
- Reset mid-run returns every output to its reset value on the next edge. No partial row is emitted.

Decomposition:
- Shared game package holds:
  - state enum {IDLE, OBST, GAP, OVER}
  - BONUS_IDX=5'd16, NUM_PATTERNS=16, LEVEL_MAX=3'd7
  - ROW_W=7, IDX_W=5
- No sub-module. The obstacle ROM stays a separate instance at the game top level, wired through tipo_obs and obstaculo. A small counter block is not worth splitting out.

Test Plan:
1. Reset, start, then three ticks (defaults) → rows 1100011 (idx 0), 0000000, 0000000. The fourth tick → 1011100 (idx 1). Each row_valid rises one cycle after its tick.
2. GAP_ROWS=0 → 8 ticks give idx 0–7. The 9th tick → 1111111 with row_is_bonus=1. The 10th tick → idx 8 pattern 1010000.
3. GAP_ROWS=0, BONUS_EVERY=15, 20 obstacle ticks → idx 0–14, bonus, then 15, 0, 1, 2. Confirms the 15→0 wrap.
4. GAP_ROWS=0, ROWS_PER_LEVEL=16 → level=1 after 16 obstacle rows. Bonus rows do not advance level. Level holds at 7 after 112+ obstacle rows.
5. Assert pause during GAP with 5 ticks → no row_valid and gap_cnt unchanged. Release pause → the remaining gap rows, then the next obstacle.
6. game_over and tick in the same cycle → no row_valid, state OVER, busy=0. A later start → the first row is idx 0 and level=0. rst mid-GAP → all outputs equal their reset values one cycle later.

Source files
------------

// File: rtl/obstacle_sequencer_pkg.sv
// Shared constants and types for the obstacle sequencer and its neighbours
// in the game top level (obstacle ROM, playfield, tick divider).
package obstacle_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OBST = 2'd1,
    GAP  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam int ROW_W        = 7;
  localparam int IDX_W        = 5;
  localparam int NUM_PATTERNS = 16;
  localparam int SEQ_W        = $clog2(NUM_PATTERNS);

  localparam logic [IDX_W-1:0] BONUS_IDX = 5'd16;
  localparam logic [2:0]       LEVEL_MAX = 3'd7;

endpackage

// File: rtl/obstacle_sequencer.sv
// Chooses the obstacle ROM index for each scroll tick, inserts gap and bonus
// rows, and raises the difficulty level as obstacle rows accumulate.
module obstacle_sequencer
  import obstacle_sequencer_pkg::*;
#(
  parameter int GAP_ROWS       = 2,
  parameter int BONUS_EVERY    = 8,
  parameter int ROWS_PER_LEVEL = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             game_over,
  input  logic             tick,
  output logic [IDX_W-1:0] tipo_obs,
  input  logic [ROW_W-1:0] obstaculo,
  output logic [ROW_W-1:0] row_out,
  output logic             row_valid,
  output logic             row_is_bonus,
  output logic [2:0]       level,
  output logic             busy
);

  localparam logic [2:0]       GAP_LAST   = 3'(GAP_ROWS);
  localparam logic [SEQ_W-1:0] BONUS_LAST = SEQ_W'(BONUS_EVERY);
  localparam logic [7:0]       LEVEL_LAST = 8'(ROWS_PER_LEVEL);

  state_t           state, state_next;
  logic [SEQ_W-1:0] seq_idx, seq_next, seq_inc;
  logic [SEQ_W-1:0] bonus_cnt, bonus_next, bonus_inc;
  logic [7:0]       obs_cnt, obs_next, obs_inc;
  logic [2:0]       gap_cnt, gap_next, gap_inc;
  logic [IDX_W-1:0] tipo_next;
  logic [ROW_W-1:0] row_next;
  logic             valid_next;
  logic             is_bonus_next;
  logic [2:0]       level_next;
  logic             running;
  logic             accept;

  assign running = (state == OBST) || (state == GAP);
  assign accept  = tick & ~pause & running;
  assign busy    = running;

  assign seq_inc   = seq_idx + 1'b1;
  assign bonus_inc = bonus_cnt + 1'b1;
  assign obs_inc   = obs_cnt + 8'd1;
  assign gap_inc   = gap_cnt + 3'd1;

  // NOTE: every variable gets a hold/default value before any branch, so no
  // path through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    tipo_next     = tipo_obs;
    row_next      = row_out;
    valid_next    = 1'b0;
    is_bonus_next = 1'b0;
    level_next    = level;
    seq_next      = seq_idx;
    bonus_next    = bonus_cnt;
    obs_next      = obs_cnt;
    gap_next      = gap_cnt;

    if (game_over) begin
      // A tick arriving with game_over is dropped along with any row.
      state_next = OVER;
      row_next   = '0;
    end else if (start && !running) begin
      state_next = OBST;
      tipo_next  = '0;
      seq_next   = '0;
      bonus_next = '0;
      obs_next   = '0;
      gap_next   = '0;
      level_next = '0;
    end else if (accept) begin
      valid_next = 1'b1;
      if (state == OBST) begin
        row_next = obstaculo;
        if (tipo_obs == BONUS_IDX) begin
          // The bonus slot does not consume a sequence index.
          is_bonus_next = 1'b1;
          bonus_next    = '0;
          tipo_next     = {1'b0, seq_idx};
        end else begin
          seq_next   = seq_inc;
          bonus_next = bonus_inc;
          if (obs_inc == LEVEL_LAST) begin
            obs_next = '0;
            if (level != LEVEL_MAX) level_next = level + 3'd1;
          end else begin
            obs_next = obs_inc;
          end
          tipo_next = (bonus_inc == BONUS_LAST) ? BONUS_IDX : {1'b0, seq_inc};
        end
        if (GAP_ROWS > 0) state_next = GAP;
      end else begin
        row_next = '0;
        if (gap_inc == GAP_LAST) begin
          gap_next   = '0;
          state_next = OBST;
        end else begin
          gap_next = gap_inc;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tipo_obs     <= '0;
      row_out      <= '0;
      row_valid    <= 1'b0;
      row_is_bonus <= 1'b0;
      level        <= '0;
      seq_idx      <= '0;
      bonus_cnt    <= '0;
      obs_cnt      <= '0;
      gap_cnt      <= '0;
    end else begin
      state        <= state_next;
      tipo_obs     <= tipo_next;
      row_out      <= row_next;
      row_valid    <= valid_next;
      row_is_bonus <= is_bonus_next;
      level        <= level_next;
      seq_idx      <= seq_next;
      bonus_cnt    <= bonus_next;
      obs_cnt      <= obs_next;
      gap_cnt      <= gap_next;
    end
  end

endmodule

// File: tb/tb_obstacle_sequencer.sv
// Three sequencer instances (default, no gaps, no gaps with long bonus cadence)
// share one stimulus stream and are compared against a row-stream model.
module tb_obstacle_sequencer;

  localparam int N = 3;
  localparam int GAP_P [N] = '{2, 0, 0};
  localparam int BE_P  [N] = '{8, 8, 15};
  localparam int RPL_P [N] = '{16, 16, 16};

  logic       clk = 1'b0;
  logic       rst, start, pause, game_over, tick;
  logic [4:0] tipo  [N];
  logic [6:0] obst  [N];
  logic [6:0] row   [N];
  logic       valid [N];
  logic       bonus [N];
  logic [2:0] lvl   [N];
  logic       busy  [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] rom(input int idx);
    case (idx)
      0:  return 7'b1100011;
      1:  return 7'b1011100;
      2:  return 7'b0110110;
      3:  return 7'b1000001;
      4:  return 7'b0011100;
      5:  return 7'b1110000;
      6:  return 7'b0000111;
      7:  return 7'b0101010;
      8:  return 7'b1010000;
      9:  return 7'b0001011;
      10: return 7'b1100110;
      11: return 7'b0111001;
      12: return 7'b1001001;
      13: return 7'b0010100;
      14: return 7'b1111000;
      15: return 7'b0001111;
      16: return 7'b1111111;
      default: return 7'b0000000;
    endcase
  endfunction

  for (genvar k = 0; k < N; k++) begin : g_rom
    assign obst[k] = rom(int'(tipo[k]));
  end

  obstacle_sequencer #(.GAP_ROWS(2), .BONUS_EVERY(8), .ROWS_PER_LEVEL(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .game_over(game_over),
    .tick(tick), .tipo_obs(tipo[0]), .obstaculo(obst[0]), .row_out(row[0]),
    .row_valid(valid[0]), .row_is_bonus(bonus[0]), .level(lvl[0]), .busy(busy[0]));

  obstacle_sequencer #(.GAP_ROWS(0), .BONUS_EVERY(8), .ROWS_PER_LEVEL(16)) dut_b (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .game_over(game_over),
    .tick(tick), .tipo_obs(tipo[1]), .obstaculo(obst[1]), .row_out(row[1]),
    .row_valid(valid[1]), .row_is_bonus(bonus[1]), .level(lvl[1]), .busy(busy[1]));

  obstacle_sequencer #(.GAP_ROWS(0), .BONUS_EVERY(15), .ROWS_PER_LEVEL(16)) dut_c (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .game_over(game_over),
    .tick(tick), .tipo_obs(tipo[2]), .obstaculo(obst[2]), .row_out(row[2]),
    .row_valid(valid[2]), .row_is_bonus(bonus[2]), .level(lvl[2]), .busy(busy[2]));

  // Reference model: a run is an endless stream of slots. Every obstacle or
  // bonus slot is followed by GAP blank slots; every BONUS_EVERY obstacles are
  // followed by one bonus. Obstacle number n uses pattern n mod 16.
  int m_pos [N], m_nobs [N], exp_row [N], exp_tipo [N];
  bit m_run [N], m_tchk [N], exp_valid [N], exp_bonus [N];

  function automatic int block_item(input int i, input int b);
    int g, r;
    g = b / (BE_P[i] + 1);
    r = b % (BE_P[i] + 1);
    if (r == BE_P[i]) return 16;
    return (g * BE_P[i] + r) % 16;
  endfunction

  function automatic int slot_item(input int i, input int pos);
    int len = GAP_P[i] + 1;
    if (pos % len != 0) return -1;
    return block_item(i, pos / len);
  endfunction

  function automatic int next_item(input int i, input int pos);
    int len = GAP_P[i] + 1;
    return block_item(i, (pos % len == 0) ? pos / len : pos / len + 1);
  endfunction

  task automatic model_step();
    int it;
    for (int i = 0; i < N; i++) begin
      exp_valid[i] = 1'b0;
      exp_bonus[i] = 1'b0;
      if (rst) begin
        m_run[i] = 1'b0; m_pos[i] = 0; m_nobs[i] = 0;
        exp_row[i] = 0; exp_tipo[i] = 0; m_tchk[i] = 1'b1;
      end else if (game_over) begin
        m_run[i] = 1'b0; exp_row[i] = 0; m_tchk[i] = 1'b0;
      end else if (start && !m_run[i]) begin
        m_run[i] = 1'b1; m_pos[i] = 0; m_nobs[i] = 0; m_tchk[i] = 1'b1;
      end else if (tick && !pause && m_run[i]) begin
        it = slot_item(i, m_pos[i]);
        exp_valid[i] = 1'b1;
        exp_row[i]   = (it < 0) ? 0 : int'(rom(it));
        exp_bonus[i] = (it == 16);
        if (it >= 0 && it != 16) m_nobs[i]++;
        m_pos[i]++;
      end
      if (m_run[i]) exp_tipo[i] = next_item(i, m_pos[i]);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int e_lvl;
    for (int i = 0; i < N; i++) begin
      e_lvl = m_nobs[i] / RPL_P[i];
      if (e_lvl > 7) e_lvl = 7;
      check($sformatf("model_valid[%0d]", i), int'(valid[i]), int'(exp_valid[i]));
      check($sformatf("model_row[%0d]", i), int'(row[i]), exp_row[i]);
      check($sformatf("model_bonus[%0d]", i), int'(bonus[i]), int'(exp_bonus[i]));
      check($sformatf("model_busy[%0d]", i), int'(busy[i]), int'(m_run[i]));
      check($sformatf("model_level[%0d]", i), int'(lvl[i]), e_lvl);
      if (m_tchk[i]) check($sformatf("model_tipo[%0d]", i), int'(tipo[i]), exp_tipo[i]);
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, sample at the next fall.
  task automatic do_cycle(input bit s, input bit p, input bit g, input bit t, input bit r);
    start = s; pause = p; game_over = g; tick = t; rst = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit         s, p, g, t;
    bit         v;
    logic [6:0] row;
    bit         busy;
    logic [4:0] tipo;
  } vec_t;

  vec_t vt [7];
  int   exp_b [10];
  int   exp_c [20];

  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0; game_over = 1'b0; tick = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_tchk[i] = 0; m_pos[i] = 0; m_nobs[i] = 0;
      exp_row[i] = 0; exp_tipo[i] = 0; exp_valid[i] = 0; exp_bonus[i] = 0;
    end

    // Test 1 vectors for the default instance: start, obstacle, two gaps, next obstacle.
    vt[0] = '{s:1, p:0, g:0, t:0, v:0, row:7'b0000000, busy:1, tipo:5'd0};
    vt[1] = '{s:0, p:0, g:0, t:1, v:1, row:7'b1100011, busy:1, tipo:5'd1};
    vt[2] = '{s:0, p:0, g:0, t:0, v:0, row:7'b1100011, busy:1, tipo:5'd1};
    vt[3] = '{s:0, p:0, g:0, t:1, v:1, row:7'b0000000, busy:1, tipo:5'd1};
    vt[4] = '{s:0, p:0, g:0, t:1, v:1, row:7'b0000000, busy:1, tipo:5'd1};
    vt[5] = '{s:0, p:0, g:0, t:1, v:1, row:7'b1011100, busy:1, tipo:5'd2};
    vt[6] = '{s:0, p:0, g:0, t:0, v:0, row:7'b1011100, busy:1, tipo:5'd2};
    for (int k = 0; k < 10; k++) exp_b[k] = (k < 8) ? k : ((k == 8) ? 16 : 8);
    for (int k = 0; k < 20; k++) exp_c[k] = (k < 15) ? k : ((k == 15) ? 16 : (k - 16 + 15) % 16);

    @(negedge clk);
    do_cycle(0, 0, 0, 0, 1);
    do_cycle(0, 0, 0, 0, 1);
    check("reset_tipo", int'(tipo[0]), 0);
    check("reset_row", int'(row[0]), 0);
    check("reset_valid", int'(valid[0]), 0);
    check("reset_bonus", int'(bonus[0]), 0);
    check("reset_level", int'(lvl[0]), 0);
    check("reset_busy", int'(busy[0]), 0);
    do_cycle(0, 0, 0, 1, 0);
    check("idle_tick_ignored", int'(valid[0]), 0);

    for (int k = 0; k < 7; k++) begin
      do_cycle(vt[k].s, vt[k].p, vt[k].g, vt[k].t, 0);
      check($sformatf("vec%0d_valid", k), int'(valid[0]), int'(vt[k].v));
      check($sformatf("vec%0d_row", k), int'(row[0]), int'(vt[k].row));
      check($sformatf("vec%0d_busy", k), int'(busy[0]), int'(vt[k].busy));
      check($sformatf("vec%0d_tipo", k), int'(tipo[0]), int'(vt[k].tipo));
    end

    // Tests 2-4: restart everything, then a run of back-to-back ticks.
    do_cycle(0, 0, 1, 0, 0);
    do_cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      do_cycle(0, 0, 0, 1, 0);
      if (k < 10) begin
        check($sformatf("b_row%0d", k), int'(row[1]), int'(rom(exp_b[k])));
        check($sformatf("b_bonus%0d", k), int'(bonus[1]), int'(exp_b[k] == 16));
      end
      check($sformatf("c_row%0d", k), int'(row[2]), int'(rom(exp_c[k])));
      check($sformatf("c_bonus%0d", k), int'(bonus[2]), int'(exp_c[k] == 16));
      if (k == 15) check("b_level_before", int'(lvl[1]), 0);
      if (k == 16) check("b_level_after16", int'(lvl[1]), 1);
      if (k == 17) check("b_level_bonus_hold", int'(lvl[1]), 1);
    end
    for (int k = 0; k < 150; k++) do_cycle(0, 0, 0, 1, 0);
    check("b_level_saturated", int'(lvl[1]), 7);

    // Test 5: pause during a gap on the default instance.
    do_cycle(0, 0, 1, 0, 0);
    do_cycle(1, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 1, 0);
    check("p_obst_row", int'(row[0]), int'(rom(0)));
    do_cycle(0, 0, 0, 1, 0);
    check("p_gap1_valid", int'(valid[0]), 1);
    for (int k = 0; k < 5; k++) begin
      do_cycle(0, 1, 0, 1, 0);
      check($sformatf("p_paused%0d_valid", k), int'(valid[0]), 0);
    end
    do_cycle(0, 0, 0, 1, 0);
    check("p_gap2_valid", int'(valid[0]), 1);
    check("p_gap2_row", int'(row[0]), 0);
    do_cycle(0, 0, 0, 1, 0);
    check("p_next_row", int'(row[0]), int'(rom(1)));

    // Test 6: game_over with a tick, restart, then reset in the middle of a gap.
    do_cycle(0, 0, 1, 1, 0);
    check("go_valid", int'(valid[0]), 0);
    check("go_busy", int'(busy[0]), 0);
    do_cycle(1, 0, 0, 0, 0);
    check("restart_level_b", int'(lvl[1]), 0);
    do_cycle(0, 0, 0, 1, 0);
    check("restart_row", int'(row[0]), int'(rom(0)));
    check("restart_level", int'(lvl[0]), 0);
    do_cycle(0, 0, 0, 0, 1);
    check("midrst_tipo", int'(tipo[0]), 0);
    check("midrst_row", int'(row[0]), 0);
    check("midrst_valid", int'(valid[0]), 0);
    check("midrst_level", int'(lvl[0]), 0);
    check("midrst_busy", int'(busy[0]), 0);

    // Random traffic against the model.
    do_cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      do_cycle($urandom_range(0, 999) < 30, $urandom_range(0, 999) < 150,
               $urandom_range(0, 999) < 8, $urandom_range(0, 999) < 450,
               $urandom_range(0, 999) < 3);
      if (!m_run[0] && $urandom_range(0, 9) == 0) do_cycle(1, 0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
